// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RISC-V core constants and the fetch packet type
package riscv_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [6:0] OP_RTYPE  = 7'd51;
    localparam logic [6:0] OP_ITYPE  = 7'd3;
    localparam logic [6:0] OP_IMM    = 7'd19;
    localparam logic [6:0] OP_STYPE  = 7'd35;
    localparam logic [6:0] OP_SBTYPE = 7'd99;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_pkt_t;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: 2-entry FIFO of fetch packets with flush; head reads zero when empty
module fetch_buffer
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       flush_i,
    input  logic       push_i,
    input  fetch_pkt_t push_pkt_i,
    input  logic       pop_i,
    output fetch_pkt_t head_o,
    output logic [1:0] occ_o
);
    fetch_pkt_t e0_q, e1_q, e0_d, e1_d;
    logic [1:0] occ_q, occ_d, wr_idx;

    assign wr_idx = occ_q - {1'b0, pop_i};
    assign occ_o  = occ_q;
    assign head_o = (occ_q != 2'd0) ? e0_q : '0;

    // shift on pop, then write the new entry into the first free slot
    always_comb begin
        e0_d  = (push_i && wr_idx == 2'd0) ? push_pkt_i : (pop_i ? e1_q : e0_q);
        e1_d  = (push_i && wr_idx == 2'd1) ? push_pkt_i : e1_q;
        occ_d = flush_i ? 2'd0 : occ_q + {1'b0, push_i} - {1'b0, pop_i};
    end

    // occupancy is the only state that needs a reset value
    always_ff @(posedge clk) begin
        if (!reset_n) occ_q <= 2'd0;
        else          occ_q <= occ_d;
    end

    // entry storage, only meaningful below occ
    always_ff @(posedge clk) begin
        e0_q <= e0_d;
        e1_q <= e1_d;
    end
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC, fixed-latency imem requests, fetch buffer and redirect handling
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              IMEM_AW  = 10
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [XLEN-1:0]    imem_rdata,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [XLEN-1:0]    if_instr,
    output logic [XLEN-1:0]    if_pc
);
    logic [XLEN-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
    logic            inflight_q, inflight_d, pop;
    logic [1:0]      occ;
    fetch_pkt_t      head, push_pkt;

    assign if_valid  = (occ != 2'd0) && !redirect_valid;
    assign pop       = if_valid && if_ready;
    // slots already committed (buffered + in flight) minus the one leaving must leave room
    assign imem_req  = reset_n && !redirect_valid &&
                       ({1'b0, occ} + {2'b0, inflight_q} < 3'd2 + {2'b0, pop});
    assign imem_addr = pc_q[IMEM_AW+1:2];
    assign push_pkt  = '{pc: req_pc_q, instr: imem_rdata};
    assign if_pc     = head.pc;
    assign if_instr  = head.instr;

    // redirect wins over sequential advance; a redirect cycle never issues
    always_comb begin
        pc_d       = redirect_valid ? (redirect_pc & ~32'h3) : (imem_req ? pc_q + 32'd4 : pc_q);
        inflight_d = imem_req;
        req_pc_d   = imem_req ? pc_q : req_pc_q;
    end

    // PC and in-flight tracking; reset overrides everything
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
            req_pc_q   <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            req_pc_q   <= req_pc_d;
        end
    end

    fetch_buffer u_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush_i   (redirect_valid),
        .push_i    (inflight_q),
        .push_pkt_i(push_pkt),
        .pop_i     (pop),
        .head_o    (head),
        .occ_o     (occ)
    );
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed and randomized checks of the fetch stage against a stream model
module tb_instruction_fetch;
    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset_n, imem_req, redirect_valid, if_valid, if_ready;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata, redirect_pc, if_instr, if_pc;

    int          tests = 0, fails = 0, pops = 0;
    logic [31:0] exp_pc = RPC;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_pc, prev_instr, tgt;

    instruction_fetch #(.RESET_PC(RPC), .IMEM_AW(10)) dut (
        .clk(clk), .reset_n(reset_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        logic [31:0] w;
        w = {22'd0, pc[11:2]};
        return (w << 22) ^ (w * 32'h9E37_79B9) ^ 32'h13;
    endfunction

    always @(posedge clk)
        imem_rdata <= imem_req ? mem_word({20'd0, imem_addr, 2'b00}) : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // settle combinational outputs, run the stream scoreboard for this cycle
    task automatic settle();
        #1;
        if (reset_n && prev_hold && !redirect_valid) begin
            chk("hold_valid", {31'd0, if_valid}, 32'd1);
            chk("hold_pc", if_pc, prev_pc);
            chk("hold_instr", if_instr, prev_instr);
        end
        if (reset_n && redirect_valid) chk("redir_novalid", {31'd0, if_valid}, 32'd0);
        if (reset_n && if_valid && if_ready) begin
            chk("stream_pc", if_pc, exp_pc);
            chk("stream_instr", if_instr, mem_word(exp_pc));
            exp_pc += 32'd4;
            pops++;
        end
        if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
        if (!reset_n) exp_pc = RPC;
        prev_hold  = reset_n && if_valid && !if_ready;
        prev_pc    = if_pc;
        prev_instr = if_instr;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        settle();
        adv();
    endtask

    task automatic do_redirect(input logic [31:0] t);
        redirect_valid = 1'b1;
        redirect_pc    = t;
        settle();
        chk("rd_req_low", {31'd0, imem_req}, 32'd0);
        adv();
        redirect_valid = 1'b0;
        if_ready       = 1'b1;
        settle();
        chk("rd_addr", {22'd0, imem_addr}, {22'd0, t[11:2]});
        chk("rd_req", {31'd0, imem_req}, 32'd1);
        chk("rd_v1", {31'd0, if_valid}, 32'd0);
        adv();
        settle();
        chk("rd_v2", {31'd0, if_valid}, 32'd0);
        adv();
        settle();
        chk("rd_v3", {31'd0, if_valid}, 32'd1);
        chk("rd_pc", if_pc, t & ~32'h3);
        adv();
    endtask

    initial begin
        reset_n = 1'b0; if_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        @(posedge clk);
        #1;
        // reset and first fetches
        settle();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        adv();
        reset_n = 1'b1;
        settle();
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_instr", if_instr, 32'd0);
        chk("addr0", {22'd0, imem_addr}, 32'h40);
        chk("req0", {31'd0, imem_req}, 32'd1);
        adv();
        settle();
        chk("addr1", {22'd0, imem_addr}, 32'h41);
        chk("lat_v1", {31'd0, if_valid}, 32'd0);
        adv();
        settle();
        chk("addr2", {22'd0, imem_addr}, 32'h42);
        chk("lat_v2", {31'd0, if_valid}, 32'd1);
        chk("first_pc", if_pc, 32'h100);
        adv();
        step();
        step();
        // stall from a fresh start
        reset_n = 1'b0;
        step();
        reset_n = 1'b1; if_ready = 1'b0;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("stall_valid", {31'd0, if_valid}, 32'd1);
            chk("stall_pc", if_pc, 32'h100);
            chk("stall_instr", if_instr, mem_word(32'h100));
            if (i == 4) chk("stall_req", {31'd0, imem_req}, 32'd0);
            adv();
        end
        if_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("release_valid", {31'd0, if_valid}, 32'd1);
            chk("release_pc", if_pc, 32'h100 + 32'(i) * 4);
            adv();
        end
        // refill to two entries, then redirect
        if_ready = 1'b0;
        step();
        step();
        do_redirect(32'h200);
        step();
        do_redirect(32'h203);
        step();
        // back-to-back redirects
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        step();
        redirect_pc = 32'h400;
        settle();
        chk("dbl_req", {31'd0, imem_req}, 32'd0);
        adv();
        redirect_valid = 1'b0;
        settle();
        chk("dbl_addr", {22'd0, imem_addr}, 32'h100);
        adv();
        step();
        settle();
        chk("dbl_pc", if_pc, 32'h400);
        adv();
        // PC wrap
        do_redirect(32'hFFFF_FFF8);
        settle();
        chk("wrap_pc1", if_pc, 32'hFFFF_FFFC);
        adv();
        settle();
        chk("wrap_pc2", if_pc, 32'h0);
        chk("wrap_valid", {31'd0, if_valid}, 32'd1);
        adv();
        // reset mid-operation with a buffered entry and a request in flight
        reset_n = 1'b0;
        settle();
        chk("mrst_req", {31'd0, imem_req}, 32'd0);
        adv();
        reset_n = 1'b1;
        settle();
        chk("mrst_valid", {31'd0, if_valid}, 32'd0);
        chk("mrst_addr", {22'd0, imem_addr}, 32'h40);
        adv();
        settle();
        chk("mrst_valid2", {31'd0, if_valid}, 32'd0);
        adv();
        settle();
        chk("mrst_pc", if_pc, RPC);
        adv();
        // randomized traffic against the stream model
        pops = 0;
        for (int i = 0; i < 3000; i++) begin
            if_ready       = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            tgt            = $urandom;
            redirect_pc    = tgt;
            reset_n        = ($urandom_range(0, 299) != 0);
            step();
        end
        redirect_valid = 1'b0; reset_n = 1'b1;
        tests++;
        assert (pops > 1000) else begin
            fails++;
            $error("FAIL rand_progress: got %0d pops expected more than 1000", pops);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the RISC-V core. It owns the program counter and drives a fixed-latency instruction memory. It buffers fetched words in a 2-entry queue and hands `{pc, instruction}` pairs downstream over a valid/ready handshake to decode, where the immediate generator sits. Taken branches come back as a redirect carrying the target (branch PC + generated immediate); the redirect flushes everything younger and restarts fetch at the target.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: byte address of the first fetch after reset.
- `IMEM_AW`, default 10: instruction memory word-address width.

Ports:
- `clk`  in  1  single clock, all state on the rising edge.
- `reset_n`  in  1  reset, synchronous and active-low.
- `imem_req`  out  1  read strobe to instruction memory.
- `imem_addr`  out  IMEM_AW  word address, equal to `pc[IMEM_AW+1:2]`.
- `imem_rdata`  in  32  read data, valid exactly 1 cycle after the `imem_req` cycle.
- `redirect_valid`  in  1  taken branch or jump from downstream.
- `redirect_pc`  in  32  target byte address.
- `if_valid`  out  1  `if_instr`/`if_pc` hold a valid pair.
- `if_ready`  in  1  downstream accepts this cycle.
- `if_instr`  out  32  fetched instruction.
- `if_pc`  out  32  byte address of `if_instr`.

## Operation
- State:
  - `pc`: next fetch address.
  - `inflight`: 1 bit, a request was issued last cycle.
  - 2-entry FIFO of `{pc, instr}` with occupancy `occ` (0..2).
- Pop: `if_valid && if_ready`. The FIFO head drives `if_*`; `if_valid = (occ != 0) && !redirect_valid`.
- Issue rule: `imem_req = reset_n && !redirect_valid && (occ + inflight - pop < 2)`.
  - On issue, `pc <= pc + 4`, 32-bit wrap, so 32'hFFFF_FFFC is followed by 0.
  - `pc` bits above IMEM_AW+1 are carried in `if_pc` but not used for addressing.
- Response: when `inflight` is set, `imem_rdata` is pushed with the PC captured at issue.
  - The push never overflows; the issue rule guarantees this.
  - Push and pop may occur in the same cycle.
- Redirect, sampled at the edge, has priority over every other event that cycle:
  - FIFO cleared, `occ <= 0`.
  - The in-flight response arriving next cycle is discarded (`inflight <= 0`).
  - `pc <= {redirect_pc[31:2], 2'b00}`; misaligned low bits are dropped.
  - No request is issued and no pop occurs in the redirect cycle.
- Back-to-back redirects: the last one wins. Each redirect cycle suppresses the request and re-flushes.
- Downstream stall (`if_ready=0`): the FIFO fills to 2 and issue stops. Outputs stay stable while `if_valid=1` and `if_ready=0`.

## Timing
- Reset, while `reset_n=0` at an edge:
  - `pc <= RESET_PC`, `occ <= 0`, `inflight <= 0`.
  - `if_valid=0`, `imem_req=0`.
  - `if_instr` and `if_pc` read 0 when empty.
- Fetch latency: a request issued in cycle N returns its data in N+1, which is pushed at the end of N+1. `if_valid` rises in N+2.
  - First cycle with `reset_n=1` is N: `imem_addr = RESET_PC[IMEM_AW+1:2]`, and the first `if_valid` appears in N+2.
- Throughput: 1 instruction per cycle with `if_ready` held high.
- Redirect latency: redirect in cycle R, target request in R+1, target instruction on `if_*` in R+3.
- Reset mid-operation: the reset edge overrides redirect, push and pop. A response to a pre-reset request is discarded.

## Structure
- Shared package `riscv_pkg` holds:
  - `XLEN = 32`.
  - `NOP_INSTR = 32'h0000_0013`.
  - Opcode constants used across decode: `OP_RTYPE = 51`, `OP_ITYPE = 3`, `OP_IMM = 19`, `OP_STYPE = 35`, `OP_SBTYPE = 99`.
  - Packed typedef `fetch_pkt_t {pc, instr}`.
- Sub-module `fetch_buffer`: 2-entry FIFO of `fetch_pkt_t` with push, pop, flush and `occ`. It has no knowledge of the PC or memory.
- The top level holds the PC, the issue/inflight logic and the redirect priority.

## Test plan
- Reset with RESET_PC=32'h100, then release, `if_ready=1` → `imem_addr` 0x40, 0x41, 0x42 on consecutive cycles; `if_pc` 0x100, 0x104, 0x108 starting 2 cycles after release, one per cycle.
- Hold `if_ready=0` for 5 cycles → occ reaches 2 and `imem_req` drops. `if_pc`/`if_instr` stay unchanged. On release, 0x100..0x10C follow with no gap and no duplicate.
- Redirect to 32'h200 while occ=2 and a request is in flight → no old PC is ever presented. `imem_addr`=0x80 the next cycle, and `if_pc`=0x200 three cycles after the redirect.
- Redirect to 32'h203 → fetch resumes at 0x200.
- Two consecutive redirect cycles (0x300, then 0x400) → only 0x400 is fetched.
- PC wrap: redirect to 32'hFFFF_FFF8 → `if_pc` FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert `reset_n=0` for one cycle while occ=1 and inflight=1 → `if_valid=0` next cycle and no stale instruction appears afterwards. Fetch restarts at RESET_PC.
